sort_frame_tx: RTL and testbench
================================

Name: sort_frame_tx

Overview:
- Frame transmitter that feeds the sorter input stream.
- Accepts one whole frame of LEN words in parallel over a valid/ready handshake.
- Buffers up to two frames in a ping-pong store.
- Serialises each frame as LEN consecutive single-cycle-valid words on dout/dout_vld, which connect directly to the sorter's din/din_vld. The sorter counts words with no framing signal, so this block must always emit exactly LEN words per frame.

Parameters:
LEN, 16, words per frame; must match the sorter; LEN >= 2.
WIDTH, 8, bits per word.
GAP, 0, idle cycles (dout_vld low) inserted after each frame's last word; 0 = back-to-back frames.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
frame_in  input  LEN*WIDTH  packed frame; word i at bits [i*WIDTH +: WIDTH]; word 0 is sent first.
frame_vld  input  1  frame_in valid.
frame_rdy  output  1  a buffer slot is free; a transfer happens when frame_vld && frame_rdy.
dout  output  WIDTH  serial word to sorter din.
dout_vld  output  1  dout valid, to sorter din_vld.
dout_last  output  1  high with the last (LEN-1) word of a frame.
busy  output  1  a frame is buffered or being sent, or a gap is in progress.

Behaviour:
- Reset (async assert, sync deassert by user): frame_rdy=0 during reset; after reset, frame_rdy=1 from the first clock. dout=0, dout_vld=0, dout_last=0, busy=0. Both buffers are empty, word counter=0, state=IDLE.
- Ping-pong store: two LEN*WIDTH registers, wr_sel, rd_sel, and a 2-bit occupancy count.
- frame_rdy = (occupancy < 2), computed from registered occupancy only. If the store is full, frame_rdy stays low in the cycle a buffer is being released; the new frame is accepted the next cycle.
- An accepted frame is written to buf[wr_sel], then wr_sel toggles.
- State machine:
  - IDLE: if occupancy > 0, go to SEND with cnt=0.
  - SEND: each cycle register dout = buf[rd_sel] word cnt and set dout_vld=1. dout_last=1 when cnt==LEN-1.
    - cnt < LEN-1: cnt increments.
    - cnt == LEN-1: the buffer is released (occupancy decrements, rd_sel toggles) and cnt wraps to 0. Next state is GAP if GAP>0; otherwise SEND if another frame is buffered (counting the release), else IDLE.
  - GAP: dout_vld=0 for exactly GAP cycles (gap counter of $clog2(GAP+1) bits), then go to SEND if occupancy>0, else IDLE.
- Latency: a frame accepted at edge N into an empty, idle block produces word 0 with dout_vld=1 after edge N+2. Acceptance registers at edge N, IDLE->SEND at N+1, registered output at N+2. Word LEN-1 follows after edge N+LEN+1.
- GAP=0 with both buffers full: 2*LEN consecutive valid cycles, no bubble.
- dout=0 and dout_last=0 whenever dout_vld=0; outputs are registered, with no combinational path from inputs.
- Accept and release in the same cycle: occupancy stays unchanged; both buffer pointers update.
- frame_in is sampled only on transfer; changes while frame_rdy=0 are ignored.
- Reset mid-frame: the partial frame is abandoned and all buffered frames are discarded. The sorter shares rst_n, so its word counter resets consistently.
- busy = (state != IDLE) || (occupancy != 0).

Optional Feature:
- Macro SORT_TX_FRMCNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0], reset 0.
  - Increments by 1 in the cycle after each dout_last word (registered with the release) and wraps from 16'hFFFF to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single frame, LEN=16, WIDTH=8, GAP=0, frame word i = 8'h10+i, accepted at edge N -> dout_vld high after edges N+2..N+17 with dout 8'h10..8'h1F in order. dout_last only with 8'h1F. busy falls after the last word; frame_rdy stays 1.
- Three frames offered back-to-back (A words 8'hA0+i, B 8'hB0+i, C 8'hC0+i), GAP=0:
  - A and B are accepted on consecutive cycles and frame_rdy drops.
  - C is accepted one cycle after A's release.
  - Output is 48 contiguous valid words: A, then B, then C.
- GAP=3 with two frames queued -> exactly 3 cycles of dout_vld=0 between 8'hAF and 8'hB0; dout=0 during the gap.
- Assert rst_n low while word 5 of frame A is on dout with frame B buffered -> immediately dout_vld=0, dout=0, busy=0. After release frame_rdy=1; a new frame D starts from word 0.
- Hold frame_vld high with changing frame_in while full -> only values present at transfer cycles appear on dout.
- With SORT_TX_FRMCNT_EN, send 3 frames -> frame_cnt reads 1, 2, 3, each step one cycle after the respective dout_last. Preload via 65536 frames, or force frame_cnt to 16'hFFFF, then send one frame -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/sort_frame_tx.sv
// sort_frame_tx: accepts whole frames over a valid/ready handshake into a
// two-entry ping-pong store and serialises each one as exactly LEN
// single-cycle-valid words for the sorter input stream.
// Optional feature macro: SORT_TX_FRMCNT_EN adds a 16-bit frame_cnt output
// counting completed frames.
module sort_frame_tx #(
   parameter int LEN   = 16,
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LEN*WIDTH-1:0] frame_in,
   input  logic                 frame_vld,
   output logic                 frame_rdy,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_vld,
   output logic                 dout_last,
`ifdef SORT_TX_FRMCNT_EN
   output logic [15:0]          frame_cnt,
`endif
   output logic                 busy
);

   localparam int FW = LEN * WIDTH;
   localparam int CW = $clog2(LEN);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [FW-1:0]    buf0_q, buf0_d;
   logic [FW-1:0]    buf1_q, buf1_d;
   logic             wr_sel_q, wr_sel_d;
   logic             rd_sel_q, rd_sel_d;
   logic [1:0]       occ_q, occ_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             dout_last_q, dout_last_d;
   logic             rdy_en_q;
   logic             accept_s;
   logic             release_s;
   logic [FW-1:0]    rd_buf_s;

   // Ready depends only on registered occupancy, so a full store never
   // accepts in the same cycle it releases a buffer.
   assign frame_rdy = rdy_en_q && (occ_q < 2'd2);
   assign busy      = (state_q != S_IDLE) || (occ_q != 2'd0);
   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign dout_last = dout_last_q;

   // Next-state: buffer writes, serialiser sequencing and occupancy tracking.
   always_comb begin
      accept_s    = frame_vld && frame_rdy;
      release_s   = 1'b0;
      rd_buf_s    = rd_sel_q ? buf1_q : buf0_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      gap_cnt_d   = gap_cnt_q;
      dout_d      = {WIDTH{1'b0}};
      dout_vld_d  = 1'b0;
      dout_last_d = 1'b0;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;

      if (accept_s) begin
         if (wr_sel_q) begin
            buf1_d = frame_in;
         end else begin
            buf0_d = frame_in;
         end
         wr_sel_d = ~wr_sel_q;
      end else begin
         wr_sel_d = wr_sel_q;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = {CW{1'b0}};
            if (occ_q != 2'd0) begin
               state_d = S_SEND;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            dout_d     = rd_buf_s[int'(cnt_q) * WIDTH +: WIDTH];
            dout_vld_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               dout_last_d = 1'b1;
               release_s   = 1'b1;
               rd_sel_d    = ~rd_sel_q;
               cnt_d       = {CW{1'b0}};
               if (GAP > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = {GW{1'b0}};
               end else if ((occ_q > 2'd1) || accept_s) begin
                  // another frame remains once this one is released
                  state_d = S_SEND;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = {GW{1'b0}};
               if (occ_q != 2'd0) begin
                  state_d = S_SEND;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case ({accept_s, release_s})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

`ifdef SORT_TX_FRMCNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   assign frame_cnt = frame_cnt_q;

   // Count a frame in the cycle after its last word was presented.
   always_comb begin
      frame_cnt_d = frame_cnt_q + {15'd0, dout_last_q};
   end
`endif

   // State, store and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         buf0_q      <= {FW{1'b0}};
         buf1_q      <= {FW{1'b0}};
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         occ_q       <= 2'd0;
         cnt_q       <= {CW{1'b0}};
         gap_cnt_q   <= {GW{1'b0}};
         dout_q      <= {WIDTH{1'b0}};
         dout_vld_q  <= 1'b0;
         dout_last_q <= 1'b0;
         rdy_en_q    <= 1'b0;
`ifdef SORT_TX_FRMCNT_EN
         frame_cnt_q <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         occ_q       <= occ_d;
         cnt_q       <= cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         dout_last_q <= dout_last_d;
         rdy_en_q    <= 1'b1;
`ifdef SORT_TX_FRMCNT_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_sort_frame_tx.sv
// Bench for sort_frame_tx: two instances (GAP=0 and GAP=3) driven with
// directed and random frames, compared every cycle against a timeline model
// that derives each frame's start/end edge from its acceptance edge.
// With SORT_TX_FRMCNT_EN defined the frame_cnt output is checked as well.
`timescale 1ns/1ps
module tb_sort_frame_tx;

   localparam int LEN   = 16;
   localparam int WIDTH = 8;
   localparam int FW    = LEN * WIDTH;
   localparam int NF    = 256;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [FW-1:0]    frame_in [2];
   logic             frame_vld [2];
   logic             frame_rdy [2];
   logic [WIDTH-1:0] dout [2];
   logic             dout_vld [2];
   logic             dout_last [2];
   logic             busy [2];
`ifdef SORT_TX_FRMCNT_EN
   logic [15:0]      frame_cnt [2];
`endif

   sort_frame_tx #(.LEN(LEN), .WIDTH(WIDTH), .GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in[0]), .frame_vld(frame_vld[0]),
      .frame_rdy(frame_rdy[0]), .dout(dout[0]), .dout_vld(dout_vld[0]),
      .dout_last(dout_last[0]),
`ifdef SORT_TX_FRMCNT_EN
      .frame_cnt(frame_cnt[0]),
`endif
      .busy(busy[0]));

   sort_frame_tx #(.LEN(LEN), .WIDTH(WIDTH), .GAP(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_in(frame_in[1]), .frame_vld(frame_vld[1]),
      .frame_rdy(frame_rdy[1]), .dout(dout[1]), .dout_vld(dout_vld[1]),
      .dout_last(dout_last[1]),
`ifdef SORT_TX_FRMCNT_EN
      .frame_cnt(frame_cnt[1]),
`endif
      .busy(busy[1]));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [FW-1:0] m_data [2][NF];
   int            m_a [2][NF];
   int            m_s [2][NF];
   int            m_e [2][NF];
   int            nfr [2];
   bit            rdyen [2];

   function automatic int gap_of(int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int occ_at(int d, int t);
      int n = 0;
      for (int k = 0; k < nfr[d]; k++) begin
         if (m_a[d][k] <= t) n++;
         if (m_e[d][k] <= t) n--;
      end
      return n;
   endfunction

   function automatic bit exp_rdy(int d, int t);
      return rdyen[d] && (occ_at(d, t) < 2);
   endfunction

   // edge at which word 0 of a frame accepted at edge t is presented
   function automatic int start_of(int d, int t);
      int pe;
      if (nfr[d] == 0) return t + 2;
      pe = m_e[d][nfr[d] - 1];
      if (gap_of(d) == 0) return (t <= pe) ? pe + 1 : t + 2;
      return (t <= pe + gap_of(d) - 1) ? pe + gap_of(d) + 1 : t + 2;
   endfunction

   function automatic int active_frame(int d, int t);
      for (int k = 0; k < nfr[d]; k++)
         if (m_s[d][k] <= t && t <= m_e[d][k]) return k;
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] exp_dout(int d, int t);
      int k = active_frame(d, t);
      if (k < 0) return '0;
      return m_data[d][k][(t - m_s[d][k]) * WIDTH +: WIDTH];
   endfunction

   function automatic bit exp_last(int d, int t);
      int k = active_frame(d, t);
      return (k >= 0) && (t == m_e[d][k]);
   endfunction

   function automatic bit exp_busy(int d, int t);
      if (occ_at(d, t) > 0) return 1'b1;
      for (int k = 0; k < nfr[d]; k++) begin
         if (m_s[d][k] <= t + 1 && t + 1 <= m_e[d][k]) return 1'b1;
         if (gap_of(d) > 0 && m_e[d][k] <= t && t <= m_e[d][k] + gap_of(d) - 1) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int exp_fcnt(int d, int t);
      int n = 0;
      for (int k = 0; k < nfr[d]; k++)
         if (m_e[d][k] <= t - 1) n++;
      return n & 16'hFFFF;
   endfunction

   // edge counter
   always @(posedge clk) cyc <= cyc + 1;

   // record accepted frames with their scheduled start/end edges
   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            nfr[d]   <= 0;
            rdyen[d] <= 1'b0;
         end else begin
            if (frame_vld[d] && exp_rdy(d, cyc) && nfr[d] < NF) begin
               m_data[d][nfr[d]] <= frame_in[d];
               m_a[d][nfr[d]]    <= cyc + 1;
               m_s[d][nfr[d]]    <= start_of(d, cyc + 1);
               m_e[d][nfr[d]]    <= start_of(d, cyc + 1) + LEN - 1;
               nfr[d]            <= nfr[d] + 1;
            end
            rdyen[d] <= 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d actual=0x%0h expected=0x%0h", nm, d, cyc, act, exp);
      end
   endtask

   // compare every output of both instances on every cycle
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("frame_rdy", d, 32'(frame_rdy[d]), 32'(exp_rdy(d, cyc)));
         chk("dout_vld",  d, 32'(dout_vld[d]),  32'(active_frame(d, cyc) >= 0));
         chk("dout",      d, 32'(dout[d]),      32'(exp_dout(d, cyc)));
         chk("dout_last", d, 32'(dout_last[d]), 32'(exp_last(d, cyc)));
         chk("busy",      d, 32'(busy[d]),      32'(exp_busy(d, cyc)));
`ifdef SORT_TX_FRMCNT_EN
         chk("frame_cnt", d, 32'(frame_cnt[d]), 32'(exp_fcnt(d, cyc)));
`endif
      end
   end

   // ---------------- stimulus ----------------
   logic [FW-1:0] src [$];
   int            ptr [2];
   bit            will_acc [2];
   int            vld_pct = 100;

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] r;
      for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [FW-1:0] mk_frame(logic [WIDTH-1:0] base);
      logic [FW-1:0] r;
      for (int i = 0; i < LEN; i++) r[i*WIDTH +: WIDTH] = base + WIDTH'(i);
      return r;
   endfunction

   // offer the next queued frame; garbage data whenever it cannot be taken
   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         if (rst_n && ptr[d] < src.size() && $urandom_range(0, 99) < vld_pct) begin
            frame_vld[d] = 1'b1;
            frame_in[d]  = exp_rdy(d, cyc) ? src[ptr[d]] : rand_frame();
            will_acc[d]  = exp_rdy(d, cyc);
         end else begin
            frame_vld[d] = 1'b0;
            frame_in[d]  = rand_frame();
            will_acc[d]  = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (will_acc[d]) ptr[d]++;
      drive();
   endtask

   function automatic bit all_idle();
      for (int d = 0; d < 2; d++)
         if (ptr[d] < src.size() || exp_busy(d, cyc) || active_frame(d, cyc) >= 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until_idle(input int budget);
      int n = 0;
      while (n < budget && !all_idle()) begin
         step();
         n++;
      end
      if (n >= budget) chk("idle_timeout", 0, 32'd0, 32'd1);
   endtask

   int n0, na, ib, np, nd;

   initial begin
      for (int d = 0; d < 2; d++) begin
         frame_vld[d] = 1'b0;
         frame_in[d]  = '0;
         ptr[d]       = 0;
         will_acc[d]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy",  0, 32'(frame_rdy[0]), 32'd0);
      chk("rst_vld",  0, 32'(dout_vld[0]),  32'd0);
      chk("rst_busy", 0, 32'(busy[0]),      32'd0);
      rst_n = 1'b1;
      step();
      chk("rdy_after_rst", 0, 32'(frame_rdy[0]), 32'd1);
      chk("rdy_after_rst", 1, 32'(frame_rdy[1]), 32'd1);

      // single frame 10..1F
      src.push_back(mk_frame(8'h10));
      drive();
      n0 = cyc + 1;
      for (int i = 0; i < 22; i++) begin
         step();
         if (cyc == n0 + 1)  chk("t1_rdy_kept", 0, 32'(frame_rdy[0]), 32'd1);
         if (cyc == n0 + 2)  chk("t1_first", 0, {dout_vld[0], dout[0]}, 32'h110);
         if (cyc == n0 + 17) chk("t1_last", 0, {dout_last[0], dout[0]}, 32'h11F);
         if (cyc == n0 + 18) chk("t1_after", 0, {busy[0], dout_vld[0]}, 32'd0);
         if (cyc == n0 + 19) chk("t1_gap_busy", 1, 32'(busy[1]), 32'd1);
         if (cyc == n0 + 20) chk("t1_gap_done", 1, 32'(busy[1]), 32'd0);
      end
      chk("t1_accept_edge", 0, 32'(m_a[0][0]), 32'(n0));

      // three frames A, B, C back to back
      ib = nfr[0];
      src.push_back(mk_frame(8'hA0));
      src.push_back(mk_frame(8'hB0));
      src.push_back(mk_frame(8'hC0));
      drive();
      na = cyc + 1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (cyc == na + 1)  chk("t2_rdy_full", 0, 32'(frame_rdy[0]), 32'd0);
         if (cyc == na + 2)  chk("t2_a0", 0, 32'(dout[0]), 32'hA0);
         if (cyc == na + 16) chk("t2_rdy_release", 0, 32'(frame_rdy[0]), 32'd0);
         if (cyc == na + 17) chk("t2_af", 0, {dout_last[0], dout[0]}, 32'h1AF);
         if (cyc == na + 18) chk("t2_b0", 0, {dout_vld[0], dout[0]}, 32'h1B0);
         if (cyc == na + 34) chk("t2_c0", 0, {dout_vld[0], dout[0]}, 32'h1C0);
         if (cyc == na + 49) chk("t2_cf", 0, {dout_last[0], dout[0]}, 32'h1CF);
         if (cyc == na + 19) chk("t2_gap", 1, {dout_vld[1], dout[1]}, 32'd0);
         if (cyc == na + 21) chk("t2_gap_b0", 1, {dout_vld[1], dout[1]}, 32'h1B0);
      end
      chk("t2_b_accept", 0, 32'(m_a[0][ib + 1]), 32'(na + 1));
      chk("t2_c_accept", 0, 32'(m_a[0][ib + 2]), 32'(na + 18));
      chk("t2_c_accept", 1, 32'(m_a[1][ib + 2]), 32'(na + 18));
      run_until_idle(200);

      // reset while word 5 of P is on dout with Q buffered
      src.push_back(mk_frame(8'h50));
      src.push_back(mk_frame(8'h60));
      drive();
      np = cyc + 1;
      for (int i = 0; i < 20 && cyc < np + 7; i++) step();
      chk("t3_word5", 0, {dout_vld[0], dout[0]}, 32'h155);
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         frame_vld[d] = 1'b0;
         will_acc[d]  = 1'b0;
         ptr[d]       = src.size();
      end
      #1;
      chk("t3_rst_out", 0, {busy[0], dout_vld[0], dout[0]}, 32'd0);
      chk("t3_rst_busy", 1, 32'(busy[1]), 32'd0);
      chk("t3_rst_rdy", 0, 32'(frame_rdy[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("t3_rdy_back", 0, 32'(frame_rdy[0]), 32'd1);
      src.push_back(mk_frame(8'h30));
      drive();
      nd = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (cyc == nd + 2) chk("t3_d0", 0, {dout_vld[0], dout[0]}, 32'h130);
      end
      run_until_idle(200);

      // random frames with gappy valid, then full pressure
      vld_pct = 60;
      for (int i = 0; i < 40; i++) src.push_back(rand_frame());
      drive();
      run_until_idle(4000);
      vld_pct = 100;
      for (int i = 0; i < 20; i++) src.push_back(rand_frame());
      drive();
      run_until_idle(2000);
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
